vc_pop_arbiter: RTL and testbench
=================================

VC_POP_ARBITER -- requirements
Module: vc_pop_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 6: word width of VC FIFO heads and D-FIFO push data.
REQ-002 Parameter DEST_BIT, default 4: bit index in a word selecting the destination (0 = D0, 1 = D1).
REQ-003 Parameter WEIGHT_VC0, default 4: consecutive VC0 grants allowed per round when VC1 is also eligible.
REQ-004 Parameter WEIGHT_VC1, default 1: consecutive VC1 grants allowed per round when VC0 is also eligible.
REQ-005 Port clk  input  1  the only clock; all state updates on its rising edge.
REQ-006 Port reset_L  input  1  asynchronous, active-low reset.
REQ-007 Port vc0_empty / vc1_empty  input  1 each  VC FIFO has no word.
REQ-008 Port vc0_data / vc1_data  input  DATA_WIDTH each  VC FIFO read data, valid the cycle after its pop.
REQ-009 Port vc0_head_dest / vc1_head_dest  input  1 each  destination of the current head word of that VC FIFO.
REQ-010 Port d0_almost_full / d1_almost_full  input  1 each  destination FIFO cannot accept one more in-flight word.
REQ-011 Port vc0_pop / vc1_pop  output  1 each  pop strobe to the VC FIFO.
REQ-012 Port d0_push / d1_push  output  1 each  push strobe to the destination FIFO.
REQ-013 Port d_data  output  DATA_WIDTH  word presented with d0_push/d1_push.
REQ-014 Port grant_vc1  output  1  registered; 1 when the current arbitration turn belongs to VC1.

Function
REQ-015 VCn is eligible in a cycle iff vcn_empty=0 and d{vcn_head_dest}_almost_full=0.
REQ-016 At most one of vc0_pop, vc1_pop is high in any cycle; the pop is combinational from eligibility and state.
REQ-017 FSM states: IDLE, TURN_VC0, TURN_VC1; reset state IDLE.
REQ-018 IDLE: VC0 eligible -> pop VC0, go to TURN_VC0, count=1; else VC1 eligible -> pop VC1, go to TURN_VC1, count=1; else stay.
REQ-019 TURN_VC0: if VC0 eligible and (count<WEIGHT_VC0 or VC1 not eligible) pop VC0 and increment count (saturating at WEIGHT_VC0); else if VC1 eligible pop VC1, go to TURN_VC1, count=1; else go to IDLE.
REQ-020 TURN_VC1: symmetric to TURN_VC0 with WEIGHT_VC1, handing over to VC0.
REQ-021 A lone eligible VC is popped every cycle regardless of its weight (work-conserving).
REQ-022 The grant counter is ceil(log2(max(WEIGHT_VC0,WEIGHT_VC1)+1)) bits wide and never wraps.
REQ-023 Pipeline latency is exactly 1: a pop in cycle N produces one push in cycle N+1, with d_data = the popped VC's data and push targeting the destination registered at cycle N.
REQ-024 No push occurs without a pop in the preceding cycle; d_data holds its last value when no push.
REQ-025 almost_full asserted in the cycle of a pop does not cancel the already-committed push in the next cycle.
REQ-026 grant_vc1 equals 1 in TURN_VC1, 0 in TURN_VC0 and IDLE.

Reset
REQ-027 On reset_L=0: state IDLE, count 0, in-flight pop flag 0, d_data 0, grant_vc1 0; vc0_pop, vc1_pop, d0_push, d1_push all 0 while reset is asserted.
REQ-028 Reset asserted mid-transfer discards the in-flight word; no push follows reset deassertion.

Structure
REQ-029 State encodings and default WEIGHT/DEST_BIT values live in the shared QoS package used by the other VC/TC blocks.
REQ-030 One sub-module, vc_pop_eligibility, computes per-VC eligibility from empty, head_dest and almost_full; FSM, counter and push register stay in the top.
REQ-031 The design is synthesizable to the team cell library; behavioural and structural versions are compared cycle-by-cycle on the same probe.

Verification
REQ-032 Both VCs non-empty, all dests D0, no almost_full, weights 4/1 -> pop sequence VC0,VC0,VC0,VC0,VC1,VC0 x4,VC1...
REQ-033 Only VC1 non-empty for 10 cycles -> vc1_pop high 10 consecutive cycles, 10 pushes, grant_vc1=1.
REQ-034 VC0 head dest D1 with d1_almost_full=1, VC1 head dest D0 -> only VC1 popped; VC0 resumes the cycle after d1_almost_full drops.
REQ-035 Single pop of VC0 word 6'h15 (DEST_BIT=4 -> D1) -> d1_push=1 and d_data=6'h15 exactly one cycle later, d0_push stays 0.
REQ-036 Assert reset_L=0 in the cycle a pop is issued -> no push afterwards, all outputs 0, state IDLE.
REQ-037 Both VCs empty after a VC0 burst -> FSM returns to IDLE, no pops, no pushes.

Source files
------------

// File: rtl/vc_pop_arbiter_pkg.sv
// rtl/vc_pop_arbiter_pkg.sv - shared QoS definitions for the VC/TC pop arbitration blocks
package vc_pop_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_TURN_VC0 = 2'd1,
      ST_TURN_VC1 = 2'd2
   } arb_state_e;

   localparam int unsigned DEF_DATA_WIDTH = 6;
   localparam int unsigned DEF_DEST_BIT   = 4;
   localparam int unsigned DEF_WEIGHT_VC0 = 4;
   localparam int unsigned DEF_WEIGHT_VC1 = 1;

   // Width needed to hold the larger weight without wrapping; at least one bit.
   function automatic int unsigned grant_cnt_width(input int unsigned w0, input int unsigned w1);
      int unsigned wmax;
      wmax = (w0 > w1) ? w0 : w1;
      if (wmax < 1) wmax = 1;
      return $clog2(wmax + 1);
   endfunction

endpackage

// File: rtl/vc_pop_eligibility.sv
// rtl/vc_pop_eligibility.sv - per-VC eligibility from FIFO occupancy and destination backpressure
module vc_pop_eligibility (
   input  logic [1:0] vc_empty,
   input  logic [1:0] vc_head_dest,
   input  logic [1:0] d_almost_full,
   output logic [1:0] vc_eligible
);

   always_comb begin
      vc_eligible = 2'b00;
      for (int i = 0; i < 2; i++) begin
         vc_eligible[i] = !vc_empty[i] && !d_almost_full[vc_head_dest[i]];
      end
   end

endmodule

// File: rtl/vc_pop_arbiter.sv
// rtl/vc_pop_arbiter.sv - weighted two-VC pop arbiter feeding D0/D1 FIFOs with a one-cycle push stage
module vc_pop_arbiter
   import vc_pop_arbiter_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned DEST_BIT   = DEF_DEST_BIT,
   parameter int unsigned WEIGHT_VC0 = DEF_WEIGHT_VC0,
   parameter int unsigned WEIGHT_VC1 = DEF_WEIGHT_VC1
) (
   input  logic                  clk,
   input  logic                  reset_L,
   input  logic                  vc0_empty,
   input  logic                  vc1_empty,
   input  logic [DATA_WIDTH-1:0] vc0_data,
   input  logic [DATA_WIDTH-1:0] vc1_data,
   input  logic                  vc0_head_dest,
   input  logic                  vc1_head_dest,
   input  logic                  d0_almost_full,
   input  logic                  d1_almost_full,
   output logic                  vc0_pop,
   output logic                  vc1_pop,
   output logic                  d0_push,
   output logic                  d1_push,
   output logic [DATA_WIDTH-1:0] d_data,
   output logic                  grant_vc1
);

   localparam int unsigned CW = grant_cnt_width(WEIGHT_VC0, WEIGHT_VC1);
   localparam logic [CW-1:0] W0  = CW'(WEIGHT_VC0);
   localparam logic [CW-1:0] W1  = CW'(WEIGHT_VC1);
   localparam logic [CW-1:0] ONE = CW'(1);

   // The head destination arrives pre-decoded; the bit index must still lie inside the word.
   if (DEST_BIT >= DATA_WIDTH) begin : g_bad_dest_bit
      $error("DEST_BIT out of range for DATA_WIDTH");
   end

   logic [1:0]            eligible;
   arb_state_e            state_q, state_d;
   logic [CW-1:0]         count_q, count_d;
   logic                  pop0, pop1;
   logic                  inflight_q, inflight_d;
   logic                  inflight_vc_q, inflight_vc_d;
   logic                  inflight_dest_q, inflight_dest_d;
   logic [DATA_WIDTH-1:0] d_data_q, d_data_d;
   logic                  grant_vc1_q, grant_vc1_d;

   vc_pop_eligibility u_elig (
      .vc_empty      ({vc1_empty, vc0_empty}),
      .vc_head_dest  ({vc1_head_dest, vc0_head_dest}),
      .d_almost_full ({d1_almost_full, d0_almost_full}),
      .vc_eligible   (eligible)
   );

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      pop0    = 1'b0;
      pop1    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (eligible[0]) begin
               pop0    = 1'b1;
               state_d = ST_TURN_VC0;
               count_d = ONE;
            end else if (eligible[1]) begin
               pop1    = 1'b1;
               state_d = ST_TURN_VC1;
               count_d = ONE;
            end
         end
         ST_TURN_VC0: begin
            if (eligible[0] && ((count_q < W0) || !eligible[1])) begin
               pop0 = 1'b1;
               if (count_q < W0) count_d = count_q + ONE;
            end else if (eligible[1]) begin
               pop1    = 1'b1;
               state_d = ST_TURN_VC1;
               count_d = ONE;
            end else begin
               state_d = ST_IDLE;
               count_d = '0;
            end
         end
         ST_TURN_VC1: begin
            if (eligible[1] && ((count_q < W1) || !eligible[0])) begin
               pop1 = 1'b1;
               if (count_q < W1) count_d = count_q + ONE;
            end else if (eligible[0]) begin
               pop0    = 1'b1;
               state_d = ST_TURN_VC0;
               count_d = ONE;
            end else begin
               state_d = ST_IDLE;
               count_d = '0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            count_d = '0;
         end
      endcase
   end

   // Pops are suppressed while reset is held so nothing is lost from the VC FIFOs.
   assign vc0_pop = pop0 && reset_L;
   assign vc1_pop = pop1 && reset_L;

   always_comb begin
      inflight_d      = vc0_pop || vc1_pop;
      inflight_vc_d   = vc1_pop;
      inflight_dest_d = vc1_pop ? vc1_head_dest : vc0_head_dest;
      grant_vc1_d     = (state_d == ST_TURN_VC1);
      d_data          = d_data_q;
      if (inflight_q) d_data = inflight_vc_q ? vc1_data : vc0_data;
      d_data_d        = d_data;
   end

   assign d0_push   = inflight_q && !inflight_dest_q;
   assign d1_push   = inflight_q &&  inflight_dest_q;
   assign grant_vc1 = grant_vc1_q;

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         state_q         <= ST_IDLE;
         count_q         <= '0;
         inflight_q      <= 1'b0;
         inflight_vc_q   <= 1'b0;
         inflight_dest_q <= 1'b0;
         d_data_q        <= '0;
         grant_vc1_q     <= 1'b0;
      end else begin
         state_q         <= state_d;
         count_q         <= count_d;
         inflight_q      <= inflight_d;
         inflight_vc_q   <= inflight_vc_d;
         inflight_dest_q <= inflight_dest_d;
         d_data_q        <= d_data_d;
         grant_vc1_q     <= grant_vc1_d;
      end
   end

endmodule

// File: tb/tb_vc_pop_arbiter.sv
// tb/tb_vc_pop_arbiter.sv - directed self-checking bench for vc_pop_arbiter
module tb_vc_pop_arbiter;

   logic       clk = 1'b0;
   logic       reset_L;
   logic       vc0_empty, vc1_empty;
   logic [5:0] vc0_data, vc1_data;
   logic       vc0_head_dest, vc1_head_dest;
   logic       d0_almost_full, d1_almost_full;
   logic       vc0_pop, vc1_pop, d0_push, d1_push, grant_vc1;
   logic [5:0] d_data;

   int checks = 0;
   int errors = 0;

   vc_pop_arbiter dut (
      .clk            (clk),
      .reset_L        (reset_L),
      .vc0_empty      (vc0_empty),
      .vc1_empty      (vc1_empty),
      .vc0_data       (vc0_data),
      .vc1_data       (vc1_data),
      .vc0_head_dest  (vc0_head_dest),
      .vc1_head_dest  (vc1_head_dest),
      .d0_almost_full (d0_almost_full),
      .d1_almost_full (d1_almost_full),
      .vc0_pop        (vc0_pop),
      .vc1_pop        (vc1_pop),
      .d0_push        (d0_push),
      .d1_push        (d1_push),
      .d_data         (d_data),
      .grant_vc1      (grant_vc1)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_outs(input string ph, input int n,
                             input logic p0, input logic p1, input logic q0, input logic q1,
                             input logic [5:0] dd, input logic g);
      chk($sformatf("%s c%0d vc0_pop", ph, n),   32'(vc0_pop),   32'(p0));
      chk($sformatf("%s c%0d vc1_pop", ph, n),   32'(vc1_pop),   32'(p1));
      chk($sformatf("%s c%0d d0_push", ph, n),   32'(d0_push),   32'(q0));
      chk($sformatf("%s c%0d d1_push", ph, n),   32'(d1_push),   32'(q1));
      chk($sformatf("%s c%0d d_data", ph, n),    32'(d_data),    32'(dd));
      chk($sformatf("%s c%0d grant_vc1", ph, n), 32'(grant_vc1), 32'(g));
   endtask

   // Inputs are set just after a rising edge; outputs are checked 2 ns later, then the next edge is taken.
   task automatic cyc(input string ph, input int n,
                      input logic p0, input logic p1, input logic q0, input logic q1,
                      input logic [5:0] dd, input logic g);
      #2;
      check_outs(ph, n, p0, p1, q0, q1, dd, g);
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset_L = 1'b0;
      vc0_empty = 1'b1; vc1_empty = 1'b1;
      vc0_data = 6'h0A; vc1_data = 6'h31;
      vc0_head_dest = 1'b0; vc1_head_dest = 1'b0;
      d0_almost_full = 1'b0; d1_almost_full = 1'b0;
      @(posedge clk);
      #1;

      // reset held: no pops even with data available
      cyc("rst", 0, 0, 0, 0, 0, 6'h00, 0);
      vc0_empty = 1'b0; vc1_empty = 1'b0;
      cyc("rst", 1, 0, 0, 0, 0, 6'h00, 0);

      // weighted 4/1 round robin, all to D0
      reset_L = 1'b1;
      cyc("wrr", 0, 1, 0, 0, 0, 6'h00, 0);
      cyc("wrr", 1, 1, 0, 1, 0, 6'h0A, 0);
      cyc("wrr", 2, 1, 0, 1, 0, 6'h0A, 0);
      cyc("wrr", 3, 1, 0, 1, 0, 6'h0A, 0);
      cyc("wrr", 4, 0, 1, 1, 0, 6'h0A, 0);
      cyc("wrr", 5, 1, 0, 1, 0, 6'h31, 1);
      cyc("wrr", 6, 1, 0, 1, 0, 6'h0A, 0);
      cyc("wrr", 7, 1, 0, 1, 0, 6'h0A, 0);
      cyc("wrr", 8, 1, 0, 1, 0, 6'h0A, 0);
      cyc("wrr", 9, 0, 1, 1, 0, 6'h0A, 0);

      // VC0 burst alone, then both empty -> back to idle, d_data held
      vc1_empty = 1'b1;
      cyc("burst", 0, 1, 0, 1, 0, 6'h31, 1);
      cyc("burst", 1, 1, 0, 1, 0, 6'h0A, 0);
      vc0_empty = 1'b1;
      cyc("drain", 0, 0, 0, 1, 0, 6'h0A, 0);
      cyc("drain", 1, 0, 0, 0, 0, 6'h0A, 0);
      cyc("drain", 2, 0, 0, 0, 0, 6'h0A, 0);

      // lone VC1 popped every cycle despite weight 1
      vc1_empty = 1'b0; vc1_data = 6'h2C;
      cyc("vc1only", 0, 0, 1, 0, 0, 6'h0A, 0);
      for (int i = 1; i < 10; i++) cyc("vc1only", i, 0, 1, 1, 0, 6'h2C, 1);
      vc1_empty = 1'b1;
      cyc("vc1only", 10, 0, 0, 1, 0, 6'h2C, 1);
      cyc("vc1only", 11, 0, 0, 0, 0, 6'h2C, 0);

      // VC0 blocked by D1 almost_full; VC1 to D0 proceeds
      vc0_empty = 1'b0; vc0_head_dest = 1'b1; vc0_data = 6'h07; d1_almost_full = 1'b1;
      vc1_empty = 1'b0;
      cyc("blk", 0, 0, 1, 0, 0, 6'h2C, 0);
      cyc("blk", 1, 0, 1, 1, 0, 6'h2C, 1);
      cyc("blk", 2, 0, 1, 1, 0, 6'h2C, 1);
      d1_almost_full = 1'b0;
      cyc("blk", 3, 1, 0, 1, 0, 6'h2C, 1);
      vc1_empty = 1'b1;
      cyc("blk", 4, 1, 0, 0, 1, 6'h07, 0);
      vc0_empty = 1'b1;
      cyc("blk", 5, 0, 0, 0, 1, 6'h07, 0);
      cyc("blk", 6, 0, 0, 0, 0, 6'h07, 0);

      // single VC0 pop of 6'h15 to D1; almost_full rising after the pop must not cancel the push
      vc0_empty = 1'b0; vc0_data = 6'h15;
      cyc("single", 0, 1, 0, 0, 0, 6'h07, 0);
      vc0_empty = 1'b1; d1_almost_full = 1'b1;
      cyc("single", 1, 0, 0, 0, 1, 6'h15, 0);
      d1_almost_full = 1'b0;
      cyc("single", 2, 0, 0, 0, 0, 6'h15, 0);
      cyc("single", 3, 0, 0, 0, 0, 6'h15, 0);

      // reset asserted in the cycle of a pop discards the in-flight word
      vc1_empty = 1'b0; vc1_head_dest = 1'b0; vc1_data = 6'h3F;
      #2;
      check_outs("rstmid", 0, 0, 1, 0, 0, 6'h15, 0);
      reset_L = 1'b0;
      #1;
      check_outs("rstmid", 1, 0, 0, 0, 0, 6'h00, 0);
      @(posedge clk);
      #1;
      cyc("rstmid", 2, 0, 0, 0, 0, 6'h00, 0);
      vc1_empty = 1'b1;
      reset_L = 1'b1;
      cyc("rstmid", 3, 0, 0, 0, 0, 6'h00, 0);
      cyc("rstmid", 4, 0, 0, 0, 0, 6'h00, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
